bod_sample_sequencer: RTL
=========================

Name: bod_sample_sequencer

Overview:
- Sequences the brownout-detection datapath.
- Paces ADC conversions on a programmable tick and presents each sample to the rate calculator with a one-cycle strobe.
- Debounces the calculator's brownout verdict and the critical BOD comparator.
- Drives the shutdown/recovery handshake to the power manager.
- Sits between the ADC interface, the BOD comparators, the rate calculator and the power-management FSM.

Parameters:
- SAMPLE_DIV, 1000: clk cycles between conversion starts (≥4).
- ADC_W, 20: ADC sample width.
- DEBOUNCE, 3: consecutive bad evaluations required to trip (≥1).
- HOLDOFF, 4096: clean cycles required before recovery.
- ADC_TIMEOUT, 64: max cycles from adc_start to adc_done.

Ports:
- clk  in  1  system clock (all logic on posedge)
- rst_n  in  1  asynchronous active-low reset
- enable  in  1  sequencer run request
- adc_start  out  1  one-cycle conversion start pulse
- adc_done  in  1  one-cycle conversion-complete pulse
- adc_data  in  ADC_W  conversion result, valid with adc_done
- sample_strobe  out  1  one-cycle pulse; sample_data valid
- sample_data  out  ADC_W  last captured sample (held between strobes)
- rate_brownout  in  1  rate-calculator verdict, valid 1 cycle after sample_strobe
- bod_warn  in  1  low-threshold comparator (sync'd upstream)
- bod_crit  in  1  critical comparator (sync'd upstream)
- err_clr  in  1  clears adc_err
- shutdown_req  out  1  level; request power-down
- adc_err  out  1  sticky conversion-timeout flag
- state  out  3  current FSM state encoding

Behaviour:
- Clock and reset: one clock (clk); reset is asynchronous and active-low (rst_n).
- Reset values: state=IDLE, all outputs 0, sample_data=0, all counters 0.
- IDLE:
  - enable=1 → WAIT_TICK, divider cleared.
- WAIT_TICK:
  - The divider counts 0..SAMPLE_DIV-1.
  - At terminal count, assert adc_start for exactly one cycle and go to CONVERT.
  - The first adc_start occurs SAMPLE_DIV cycles after entry.
- CONVERT:
  - The timeout counter runs.
  - adc_done → capture adc_data into sample_data and pulse sample_strobe in the next cycle; go to EVAL.
  - Counter reaches ADC_TIMEOUT without adc_done → set adc_err and return to WAIT_TICK; trip_cnt is unchanged.
  - adc_done outside CONVERT is ignored.
- EVAL (one cycle, aligned with rate_brownout validity):
  - bad = rate_brownout | bod_crit.
  - bad → trip_cnt+1 (saturating at DEBOUNCE); otherwise trip_cnt=0.
  - trip_cnt reaches DEBOUNCE → TRIPPED; otherwise → WAIT_TICK.
  - The divider is not cleared on re-entry, so the sample period stays exactly SAMPLE_DIV.
- bod_crit fast path:
  - bod_crit=1 in WAIT_TICK, CONVERT or EVAL → TRIPPED at the next edge, bypassing debounce.
  - This has priority over every other transition except reset.
- TRIPPED:
  - shutdown_req=1, registered and asserted on the same edge as state entry.
  - Stay until bod_warn=0 and bod_crit=0, then → HOLDOFF.
- HOLDOFF:
  - shutdown_req stays 1 and the holdoff counter runs.
  - Any bod_warn or bod_crit → counter restarts at 0.
  - Counter reaches HOLDOFF-1 → shutdown_req=0, trip_cnt=0, go to WAIT_TICK (or IDLE if enable=0).
- enable=0:
  - In WAIT_TICK, CONVERT or EVAL → IDLE at the next edge, counters cleared, adc_start suppressed.
  - In TRIPPED or HOLDOFF it is ignored; shutdown must complete.
- adc_err:
  - Sticky; err_clr clears it.
  - A simultaneous timeout and err_clr leaves adc_err=1 (set wins).
- State encoding (package constants): IDLE=0, WAIT_TICK=1, CONVERT=2, EVAL=3, TRIPPED=4, HOLDOFF=5. Unused codes recover to IDLE.
- Counter widths: $clog2 of the respective parameter, with no wrap reachable.

Optional Feature:
- Macro BOD_EVENT_LOG_EN.
- Defined: adds outputs trip_count[7:0] and trip_sample[ADC_W-1:0].
  - trip_count increments (saturating at 255) on each entry to TRIPPED.
  - trip_sample latches sample_data on that entry.
  - Both are cleared only by rst_n.
- Undefined: the ports are absent and no extra registers exist.

Decomposition:
- Package bod_pkg: state encoding constants, default ADC_W, state width.
- One natural sub-module, bod_tick_gen: parameterised divider with clear and enable, producing the terminal-count pulse. It is reused for the holdoff counter with restart input.

Test Plan:
- SAMPLE_DIV=8, enable rises at t0, adc_done returned 3 cycles after each adc_start → adc_start at t0+8, t0+16…; sample_strobe 1 cycle after each adc_done; sample_data equals the driven value (e.g. 20'h0ABCD).
- DEBOUNCE=3, rate_brownout=1 on evaluations 1 and 2 and 0 on evaluation 3 → no trip; then 3 consecutive 1s → state=4 and shutdown_req=1 right after the third EVAL.
- bod_crit pulsed mid-CONVERT → TRIPPED next edge, shutdown_req=1, no further adc_start.
- HOLDOFF=16, comparators clear, bod_warn glitch at holdoff count 10 → shutdown_req stays 1 for 16 clean cycles after the glitch, then 0 and state=1.
- adc_done withheld, ADC_TIMEOUT=64 → adc_err=1 at cycle 64, state returns to 1; err_clr asserted alone → adc_err=0; err_clr coincident with a new timeout → adc_err remains 1.
- rst_n asserted asynchronously mid-HOLDOFF → all outputs 0 immediately, state=0; enable=0 in CONVERT → IDLE with no further adc_start.

Source files
------------

// File: rtl/bod_pkg.sv
// bod_pkg: state encoding and shared defaults for the brownout sample sequencer
package bod_pkg;
  localparam int STATE_W = 3;
  localparam int ADC_W_DEF = 20;
  typedef enum logic [STATE_W-1:0] {
    S_IDLE      = 3'd0,
    S_WAIT_TICK = 3'd1,
    S_CONVERT   = 3'd2,
    S_EVAL      = 3'd3,
    S_TRIPPED   = 3'd4,
    S_HOLDOFF   = 3'd5
  } state_t;
endpackage

// File: rtl/bod_tick_gen.sv
// bod_tick_gen: divider counting 0..N-1 with synchronous clear, flags the terminal count
// Ports: clk, rst_n (async active-low), clr (restart at 0), en (count), tc (terminal count, suppressed by clr)
module bod_tick_gen #(
  parameter int N = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic tc
);
  localparam int CW = N > 1 ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);
  logic [CW-1:0] cnt;
  assign tc = en && !clr && cnt == LAST;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt <= '0;
    else if (clr) cnt <= '0;
    else if (en) cnt <= tc ? '0 : cnt + 1'b1;
endmodule

// File: rtl/bod_sample_sequencer.sv
// bod_sample_sequencer: paces ADC sampling, debounces brownout verdicts, drives shutdown/recovery
// Ports: clk, rst_n (async active-low), enable; adc_start/adc_done/adc_data ADC handshake;
//   sample_strobe/sample_data to the rate calculator; rate_brownout, bod_warn, bod_crit verdicts;
//   err_clr, shutdown_req, adc_err (sticky timeout), state (FSM encoding).
// Optional BOD_EVENT_LOG_EN adds trip_count (saturating trip counter) and trip_sample (sample at trip).
module bod_sample_sequencer
  import bod_pkg::*;
#(
  parameter int SAMPLE_DIV  = 1000,
  parameter int ADC_W       = ADC_W_DEF,
  parameter int DEBOUNCE    = 3,
  parameter int HOLDOFF     = 4096,
  parameter int ADC_TIMEOUT = 64
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               enable,
  output logic               adc_start,
  input  logic               adc_done,
  input  logic [ADC_W-1:0]   adc_data,
  output logic               sample_strobe,
  output logic [ADC_W-1:0]   sample_data,
  input  logic               rate_brownout,
  input  logic               bod_warn,
  input  logic               bod_crit,
  input  logic               err_clr,
  output logic               shutdown_req,
  output logic               adc_err,
  output logic [STATE_W-1:0] state
`ifdef BOD_EVENT_LOG_EN
  ,
  output logic [7:0]         trip_count,
  output logic [ADC_W-1:0]   trip_sample
`endif
);
  localparam int TW = $clog2(DEBOUNCE + 1);
  localparam logic [TW-1:0] TRIP_LAST = TW'(DEBOUNCE - 1);
  state_t st;
  logic [TW-1:0] trip_cnt;
  logic active, tick, to_tc, ho_tc, trip_now, timeout;
  assign state = st;
  // The debounce trip is the verdict that would take trip_cnt to DEBOUNCE; enable=0 outranks it, bod_crit does not.
  always_comb begin
    active = st == S_WAIT_TICK || st == S_CONVERT || st == S_EVAL;
    trip_now = active && (bod_crit || (enable && st == S_EVAL && rate_brownout && trip_cnt >= TRIP_LAST));
    timeout = enable && !bod_crit && st == S_CONVERT && to_tc;
  end
  // Sample divider free-runs while sampling so the period is independent of conversion latency.
  bod_tick_gen #(.N(SAMPLE_DIV)) u_div (
    .clk(clk), .rst_n(rst_n), .clr(!active), .en(1'b1), .tc(tick)
  );
  bod_tick_gen #(.N(ADC_TIMEOUT)) u_timeout (
    .clk(clk), .rst_n(rst_n), .clr(st != S_CONVERT || adc_done || sample_strobe), .en(1'b1), .tc(to_tc)
  );
  bod_tick_gen #(.N(HOLDOFF)) u_holdoff (
    .clk(clk), .rst_n(rst_n), .clr(st != S_HOLDOFF || bod_warn || bod_crit), .en(1'b1), .tc(ho_tc)
  );
  // CONVERT is held through the strobe cycle so that EVAL lines up with rate_brownout.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      st <= S_IDLE;
      adc_start <= 1'b0;
      sample_strobe <= 1'b0;
      sample_data <= '0;
      shutdown_req <= 1'b0;
      adc_err <= 1'b0;
      trip_cnt <= '0;
    end else begin
      adc_start <= 1'b0;
      sample_strobe <= 1'b0;
      adc_err <= timeout || (adc_err && !err_clr);
      if (trip_now) begin
        st <= S_TRIPPED;
        shutdown_req <= 1'b1;
      end else if (active && !enable) begin
        st <= S_IDLE;
        trip_cnt <= '0;
      end else
        case (st)
          S_IDLE: if (enable) st <= S_WAIT_TICK;
          S_WAIT_TICK:
            if (tick) begin
              adc_start <= 1'b1;
              st <= S_CONVERT;
            end
          S_CONVERT:
            if (sample_strobe) st <= S_EVAL;
            else if (adc_done) begin
              sample_data <= adc_data;
              sample_strobe <= 1'b1;
            end else if (to_tc) st <= S_WAIT_TICK;
          S_EVAL: begin
            trip_cnt <= rate_brownout ? trip_cnt + 1'b1 : '0;
            st <= S_WAIT_TICK;
          end
          S_TRIPPED: if (!bod_warn && !bod_crit) st <= S_HOLDOFF;
          S_HOLDOFF:
            if (ho_tc) begin
              shutdown_req <= 1'b0;
              trip_cnt <= '0;
              st <= enable ? S_WAIT_TICK : S_IDLE;
            end
          default: begin
            st <= S_IDLE;
            shutdown_req <= 1'b0;
          end
        endcase
    end
`ifdef BOD_EVENT_LOG_EN
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      trip_count <= '0;
      trip_sample <= '0;
    end else if (trip_now) begin
      trip_count <= trip_count == 8'hFF ? trip_count : trip_count + 1'b1;
      trip_sample <= sample_data;
    end
`endif
endmodule
